serial_subtractor_8bit: RTL and testbench



---
 rtl/arith_seq_pkg.sv | 13 +
 rtl/full_subtractor_bit.sv | 16 +
 rtl/serial_subtractor_8bit.sv | 159 +++++++++++++++
 tb/tb_serial_subtractor_8bit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/arith_seq_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state
// encoding and the default operand width.
package arith_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seq_state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage : arith_seq_pkg

// File: rtl/full_subtractor_bit.sv
// Single-bit full subtractor: d = x - y - bin, with borrow-out.
// Purely combinational; the serial subtractor reuses one instance every cycle.
module full_subtractor_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    // A borrow leaves this bit when y exceeds x, or when x equals y and a
    // borrow arrived from below.
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : full_subtractor_bit

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB
// first. start is accepted whenever the block is idle or finishing (DONE),
// so back-to-back operations sustain one result every WIDTH+1 cycles.
// diff/borrow_out hold the last completed result until the next completion.
module serial_subtractor_8bit
    import arith_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    seq_state_e       state_r;
    seq_state_e       state_next_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] res_next_s;
    logic             brw_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_out_r;
    logic             busy_r;
    logic             done_r;
    logic             bit_s;
    logic             bout_s;
    logic             accept_s;
    logic             last_s;

    // One shared bit cell operates on the current LSBs and the running borrow.
    full_subtractor_bit u_fsb (
        .x    (a_sh_r[0]),
        .y    (b_sh_r[0]),
        .bin  (brw_r),
        .d    (bit_s),
        .bout (bout_s)
    );

    // New result bit enters at the MSB so after WIDTH shifts bit 0 sits at LSB.
    assign res_next_s = {bit_s, res_r[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic plus accept / last-bit strobes; start only matters when ready.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = SHIFT;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = DONE;
                    last_s       = 1'b1;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                if (start) begin
                    state_next_s = SHIFT;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Operand capture on accept, then one right-shift per SHIFT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r <= {WIDTH{1'b0}};
            b_sh_r <= {WIDTH{1'b0}};
            res_r  <= {WIDTH{1'b0}};
            brw_r  <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            a_sh_r <= a;
            b_sh_r <= b;
            res_r  <= res_r;
            brw_r  <= borrow_in;
            cnt_r  <= {CNT_W{1'b0}};
        end else if (state_r == SHIFT) begin
            a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
            res_r  <= res_next_s;
            brw_r  <= bout_s;
            // Wrap to zero on the last bit so the count never passes WIDTH-1.
            cnt_r  <= last_s ? {CNT_W{1'b0}} : (cnt_r + {{(CNT_W-1){1'b0}}, 1'b1});
        end else begin
            a_sh_r <= a_sh_r;
            b_sh_r <= b_sh_r;
            res_r  <= res_r;
            brw_r  <= brw_r;
            cnt_r  <= cnt_r;
        end
    end

    // Result registers update only when the final bit is produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_r       <= {WIDTH{1'b0}};
            borrow_out_r <= 1'b0;
        end else if (last_s) begin
            diff_r       <= res_next_s;
            borrow_out_r <= bout_s;
        end else begin
            diff_r       <= diff_r;
            borrow_out_r <= borrow_out_r;
        end
    end

    // Status flags registered from the next state so they align with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s == SHIFT);
            done_r <= (state_next_s == DONE);
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign diff       = diff_r;
    assign borrow_out = borrow_out_r;

endmodule : serial_subtractor_8bit

// File: tb/tb_serial_subtractor_8bit.sv
// Bench for serial_subtractor_8bit: an arithmetic/timing model checks every
// cycle, and directed scenarios pin results with hand-computed constants.
module tb_serial_subtractor_8bit;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int n_cmp;
    int n_fail;

    serial_subtractor_8bit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An accepted op keeps the block busy for W cycles, then reports
    // (a-b-bin) mod 2^W and the unsigned borrow for exactly one cycle.
    int           m_left;
    bit           m_done;
    logic [W-1:0] m_diff;
    bit           m_bo;
    logic [W-1:0] m_pdiff;
    bit           m_pbo;

    always @(posedge clk) begin
        logic         s_start;
        logic [W-1:0] s_a;
        logic [W-1:0] s_b;
        logic         s_bin;
        int           ia;
        int           ib;
        s_start = start;
        s_a     = a;
        s_b     = b;
        s_bin   = borrow_in;
        #1;
        if (!rst_n) begin
            m_left = 0;
            m_done = 1'b0;
            m_diff = '0;
            m_bo   = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_diff = m_pdiff;
                    m_bo   = m_pbo;
                end
            end else if (s_start === 1'b1) begin
                ia      = int'(s_a);
                ib      = int'(s_b) + int'(s_bin);
                m_left  = W;
                m_pdiff = W'((ia - ib + 256) % 256);
                m_pbo   = (ia < ib);
            end
        end
        check("busy",       {31'd0, busy},       {31'd0, (m_left > 0)});
        check("done",       {31'd0, done},       {31'd0, m_done});
        check("diff",       {24'd0, diff},       {24'd0, m_diff});
        check("borrow_out", {31'd0, borrow_out}, {31'd0, m_bo});
    end

    // ---------------- directed stimulus ----------------
    // Issue one op and wait (bounded) for done; returns busy cycles and latency.
    task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tbin, input logic [W-1:0] exp_d, input logic exp_bo);
        int busy_cnt;
        int lat;
        bit seen;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_; borrow_in = tbin;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        seen = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
        end
        check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({name, "_diff"}, {24'd0, diff}, {24'd0, exp_d});
        check({name, "_bo"}, {31'd0, borrow_out}, {31'd0, exp_bo});
        check({name, "_busy_cycles"}, busy_cnt, 32'd8);
        check({name, "_latency"}, lat, 32'd8);
    endtask

    initial begin
        int  dones;
        int  gap;
        bit  seen;
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        borrow_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {24'd0, diff}, 32'd0);
        check("rst_bo",   {31'd0, borrow_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("zero",  8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        run_op("wrap1", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        run_op("c8_37", 8'hC8, 8'h37, 1'b1, 8'h90, 1'b0);
        run_op("80_80", 8'h80, 8'h80, 1'b1, 8'hFF, 1'b1);
        run_op("ff_ff", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);

        // start pulsed mid-operation must be ignored
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h01; borrow_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; a = 8'h55; b = 8'h55;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            if (done === 1'b1) begin
                dones++;
                check("ign_diff", {24'd0, diff}, 32'h0F);
                check("ign_bo", {31'd0, borrow_out}, 32'd0);
            end
            @(negedge clk);
        end
        check("ign_done_count", dones, 32'd1);

        // start held through DONE: back-to-back accept
        start = 1'b1; a = 8'h05; b = 8'h07; borrow_in = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("b2b_first_seen", {31'd0, seen}, 32'd1);
        check("b2b_first_diff", {24'd0, diff}, 32'hFE);
        check("b2b_first_bo", {31'd0, borrow_out}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        gap = 0;
        seen = 1'b0;
        for (int i = 2; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                gap = i;
                break;
            end
        end
        check("b2b_second_seen", {31'd0, seen}, 32'd1);
        check("b2b_gap", gap, 32'd9);
        check("b2b_second_diff", {24'd0, diff}, 32'hFE);
        check("b2b_second_bo", {31'd0, borrow_out}, 32'd1);

        // reset in the middle of an operation
        @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h11; borrow_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_diff", {24'd0, diff}, 32'd0);
        check("mid_rst_bo", {31'd0, borrow_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("post_rst_no_done", dones, 32'd0);
        run_op("aa_11", 8'hAA, 8'h11, 1'b0, 8'h99, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_serial_subtractor_8bit
